// File: rtl/clock_mode_controller.sv
// Front-end controller for DigitalClock: synchronises and debounces the board switches,
// detects presses and sequences mode, field select, increment, alarm and stopwatch controls.
module clock_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       global_reset_n,
    input  logic       mode_sw,
    input  logic       start_sw,
    input  logic       reset_sw,
    output logic [1:0] mode,
    output logic [1:0] select,
    output logic       increment,
    output logic       alarm_enable,
    output logic       stopwatch_run,
    output logic       stopwatch_clear
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX) + 1;

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_PER   = RW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        MODE_CLOCK      = 2'd0,
        MODE_CLOCK_EDIT = 2'd1,
        MODE_ALARM_EDIT = 2'd2,
        MODE_STOPWATCH  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SEC  = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_HOUR = 2'd3
    } select_t;

    // Switch index: 0 = mode, 1 = start, 2 = reset
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_q;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    rise;

    mode_t         mode_q;
    mode_t         next_mode;
    select_t       select_q;
    logic [RW-1:0] rep_cnt;
    logic          rep_phase;

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= {reset_sw, start_sw, mode_sw};
            sync2    <= sync1;
            stable_q <= stable;
            // A level is accepted only after it has differed from the stable value for a full window
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign rise      = stable & ~stable_q;
    assign next_mode = mode_t'(mode_q + 2'd1);

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            mode_q          <= MODE_CLOCK;
            select_q        <= SEL_NONE;
            increment       <= 1'b0;
            alarm_enable    <= 1'b0;
            stopwatch_run   <= 1'b0;
            stopwatch_clear <= 1'b0;
            rep_cnt         <= '0;
            rep_phase       <= 1'b0;
        end else begin
            increment       <= 1'b0;
            stopwatch_clear <= 1'b0;
            if (rise[0]) begin
                mode_q    <= next_mode;
                select_q  <= (next_mode == MODE_CLOCK_EDIT || next_mode == MODE_ALARM_EDIT)
                             ? SEL_SEC : SEL_NONE;
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
            end else begin
                case (mode_q)
                    MODE_CLOCK: begin
                        if (rise[1]) begin
                            alarm_enable <= ~alarm_enable;
                        end
                    end
                    MODE_STOPWATCH: begin
                        if (rise[2]) begin
                            stopwatch_clear <= 1'b1;
                            stopwatch_run   <= 1'b0;
                        end else if (rise[1]) begin
                            stopwatch_run <= ~stopwatch_run;
                        end
                    end
                    default: begin
                        if (rise[2]) begin
                            select_q <= (select_q == SEL_HOUR) ? SEL_SEC : select_t'(select_q + 2'd1);
                        end
                        // rep_cnt counts edges since the last pulse; zero means auto-repeat is idle
                        if (rise[1]) begin
                            increment <= 1'b1;
                            rep_cnt   <= RW'(1);
                            rep_phase <= 1'b0;
                        end else if (!stable[1]) begin
                            rep_cnt   <= '0;
                            rep_phase <= 1'b0;
                        end else if (rep_cnt != '0) begin
                            if (rep_cnt == (rep_phase ? REP_PER : REP_DELAY)) begin
                                increment <= 1'b1;
                                rep_cnt   <= RW'(1);
                                rep_phase <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + RW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign mode   = mode_q;
    assign select = select_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Scoreboard bench for clock_mode_controller: directed switch presses push expected output
// events; a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_clock_mode_controller;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DB + 3;

    logic       clk;
    logic       global_reset_n;
    logic       mode_sw;
    logic       start_sw;
    logic       reset_sw;
    logic [1:0] mode;
    logic [1:0] select;
    logic       increment;
    logic       alarm_enable;
    logic       stopwatch_run;
    logic       stopwatch_clear;

    typedef struct {
        logic [1:0] m;
        logic [1:0] s;
        logic       inc;
        logic       alm;
        logic       run;
        logic       clr;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [5:0] last_snap = '0;

    clock_mode_controller #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .mode_sw        (mode_sw),
        .start_sw       (start_sw),
        .reset_sw       (reset_sw),
        .mode           (mode),
        .select         (select),
        .increment      (increment),
        .alarm_enable   (alarm_enable),
        .stopwatch_run  (stopwatch_run),
        .stopwatch_clear(stopwatch_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every level change or pulse on the outputs must match the oldest expected event
    always @(negedge clk) begin
        logic [5:0] snap;
        exp_t       e;
        snap = {mode, select, alarm_enable, stopwatch_run};
        if (snap != last_snap || increment || stopwatch_clear) begin
            last_snap = snap;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_event: got mode=%0d sel=%0d inc=%0b alarm=%0b run=%0b clr=%0b at cyc=%0d, expected no event",
                         mode, select, increment, alarm_enable, stopwatch_run, stopwatch_clear, cyc);
            end else begin
                e = q.pop_front();
                if (mode !== e.m || select !== e.s || increment !== e.inc || alarm_enable !== e.alm ||
                    stopwatch_run !== e.run || stopwatch_clear !== e.clr || (e.cyc >= 0 && cyc != e.cyc)) begin
                    bad++;
                    $display("[TB] FAIL event: got mode=%0d sel=%0d inc=%0b alarm=%0b run=%0b clr=%0b cyc=%0d, expected mode=%0d sel=%0d inc=%0b alarm=%0b run=%0b clr=%0b cyc=%0d",
                             mode, select, increment, alarm_enable, stopwatch_run, stopwatch_clear, cyc,
                             e.m, e.s, e.inc, e.alm, e.run, e.clr, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] m, input logic [1:0] s, input logic inc,
                            input logic alm, input logic run, input logic clr, input int at);
        exp_t e;
        e.m   = m;
        e.s   = s;
        e.inc = inc;
        e.alm = alm;
        e.run = run;
        e.clr = clr;
        e.cyc = at;
        q.push_back(e);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_sw(input int which, input logic v);
        case (which)
            0: mode_sw = v;
            1: start_sw = v;
            2: reset_sw = v;
            3: begin start_sw = v; reset_sw = v; end
            default: begin mode_sw = v; start_sw = v; end
        endcase
    endtask

    // which: 0 mode, 1 start, 2 reset, 3 start+reset, 4 mode+start
    task automatic apply_stimulus(input int which, input int hold, input bit expect_event,
                                  input logic [1:0] m, input logic [1:0] s,
                                  input logic alm, input logic run, input logic clr);
        @(negedge clk);
        if (expect_event) push_exp(m, s, 1'b0, alm, run, clr, cyc + LAT);
        set_sw(which, 1'b1);
        repeat (hold) @(negedge clk);
        set_sw(which, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int t0;
        global_reset_n = 1'b0;
        mode_sw  = 1'b0;
        start_sw = 1'b0;
        reset_sw = 1'b0;
        #1;
        check_output("reset_mode",   int'(mode), 0);
        check_output("reset_select", int'(select), 0);
        check_output("reset_levels", int'({increment, alarm_enable, stopwatch_run, stopwatch_clear}), 0);
        repeat (3) @(negedge clk);
        global_reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] mode cycling");
        apply_stimulus(0, 10, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(0, 10, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(0, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(0, 10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] glitch rejection");
        for (int i = 0; i < 12; i++) begin
            mode_sw = ((i % 4) < 2);
            @(negedge clk);
        end
        mode_sw = 1'b0;
        repeat (15) @(negedge clk);
        check_output("glitch_mode", int'(mode), 0);

        $display("[TB] select cycling");
        apply_stimulus(0, 10, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(2, 10, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(2, 10, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
        apply_stimulus(2, 10, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);

        $display("[TB] auto-repeat");
        @(negedge clk);
        t0 = cyc + LAT;
        push_exp(2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, t0);
        push_exp(2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, t0 + RD);
        for (int k = 1; k <= 5; k++) begin
            push_exp(2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, t0 + RD + k * RP);
        end
        start_sw = 1'b1;
        repeat (46) @(negedge clk);
        start_sw = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] stopwatch and alarm");
        apply_stimulus(0, 10, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(0, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(2, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(3, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(4, 10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(2, 10, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1, 10, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(0, 10, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(0, 10, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);
        check_output("alarm_persist", int'(alarm_enable), 1);

        $display("[TB] async reset mid-debounce");
        @(negedge clk);
        start_sw = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        push_exp(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        global_reset_n = 1'b0;
        #1;
        check_output("async_mode",   int'(mode), 0);
        check_output("async_select", int'(select), 0);
        check_output("async_levels", int'({increment, alarm_enable, stopwatch_run, stopwatch_clear}), 0);
        @(negedge clk);
        start_sw = 1'b0;
        repeat (2) @(negedge clk);
        global_reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_output("post_reset_mode",   int'(mode), 0);
        check_output("post_reset_select", int'(select), 0);

        check_output("pending_events", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
